// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined add/sub, one carry-lookahead lane resolved per stage
// Optional saturation: define CLA_ADDSUB_SAT_EN to add the sat_i input.
module cla_addsub_pipe #(
   parameter int WIDTH  = 16,
   parameter int LANE_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [1:0]       op_i,
   input  logic             cin_i,
`ifdef CLA_ADDSUB_SAT_EN
   input  logic             sat_i,
`endif
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o,
   output logic             neg_o
);
   localparam int NL = WIDTH / LANE_W;

   // Flat sum-of-products carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0
   function automatic logic [LANE_W:0] lane_add(input logic [LANE_W-1:0] x,
                                                input logic [LANE_W-1:0] y,
                                                input logic c0);
      logic [LANE_W-1:0] p, g;
      logic [LANE_W:0]   c;
      logic              t;
      p = x ^ y;
      g = x & y;
      c = '0;
      c[0] = c0;
      for (int i = 0; i < LANE_W; i++) begin
         t = c0;
         for (int m = 0; m <= i; m++) t = t & p[m];
         c[i+1] = t;
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int m = j + 1; m <= i; m++) t = t & p[m];
            c[i+1] = c[i+1] | t;
         end
      end
      return {c[LANE_W], p ^ c[LANE_W-1:0]};
   endfunction

   logic [WIDTH-1:0] a_q [NL];
   logic [WIDTH-1:0] b_q [NL];
   logic [WIDTH-1:0] s_q [NL];
   logic             c_q [NL];
   logic             v_q [NL];
   logic [WIDTH-1:0] s_d [NL];
   logic             cn_d [NL];
`ifdef CLA_ADDSUB_SAT_EN
   logic             sat_q [NL];
`endif

   logic             out_valid_q, cout_q, ovf_q, zero_q, neg_q;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             ovf_d, a_msb, b_msb, adv;

   assign adv        = !out_valid_q | out_ready_i;
   assign in_ready_o = adv;
   assign a_msb      = a_q[NL-1][WIDTH-1];
   assign b_msb      = b_q[NL-1][WIDTH-1];

   always_comb begin
      logic [LANE_W:0] lr;
      lr = '0;
      for (int k = 0; k < NL; k++) begin
         lr = lane_add(a_q[k][k*LANE_W +: LANE_W], b_q[k][k*LANE_W +: LANE_W], c_q[k]);
         s_d[k] = s_q[k];
         s_d[k][k*LANE_W +: LANE_W] = lr[LANE_W-1:0];
         cn_d[k] = lr[LANE_W];
      end
      ovf_d = (a_msb == b_msb) & (s_d[NL-1][WIDTH-1] != a_msb);
      sum_d = s_d[NL-1];
`ifdef CLA_ADDSUB_SAT_EN
      if (sat_q[NL-1] && ovf_d)
         sum_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NL; k++) v_q[k] <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
      end else if (adv) begin
         v_q[0] <= in_valid_i;
         for (int k = 1; k < NL; k++) v_q[k] <= v_q[k-1];
         out_valid_q <= v_q[NL-1];
         if (v_q[NL-1]) begin
            sum_q  <= sum_d;
            cout_q <= cn_d[NL-1];
            ovf_q  <= ovf_d;
            zero_q <= (sum_d == '0);
            neg_q  <= sum_d[WIDTH-1];
         end
      end
   end

   // Operand/partial-sum payload needs no reset; the valid bits qualify it.
   always_ff @(posedge clk_i) begin
      if (adv) begin
         a_q[0] <= a_i;
         b_q[0] <= op_i[0] ? ~b_i : b_i;
         s_q[0] <= '0;
         c_q[0] <= op_i[1] ? cin_i : op_i[0];
`ifdef CLA_ADDSUB_SAT_EN
         sat_q[0] <= sat_i;
`endif
         for (int k = 1; k < NL; k++) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
            s_q[k] <= s_d[k-1];
            c_q[k] <= cn_d[k-1];
`ifdef CLA_ADDSUB_SAT_EN
            sat_q[k] <= sat_q[k-1];
`endif
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign sum_o       = sum_q;
   assign cout_o      = cout_q;
   assign ovf_o       = ovf_q;
   assign zero_o      = zero_q;
   assign neg_o       = neg_q;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - randomized scoreboard bench for cla_addsub_pipe
module tb_cla_addsub_pipe;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [15:0] a = '0, b = '0;
   logic [1:0]  op = '0;
   logic        cin = 1'b0, sat = 1'b0;
   logic        out_valid, out_ready = 1'b1;
   logic [15:0] sum;
   logic        cout, ovf, zero, neg;

   int checks = 0, errors = 0, cyc = 0;
   logic [19:0] q[$];
   int          deliv_cyc[$];
   logic        prev_stall = 1'b0;
   logic [19:0] prev_out = '0;
   logic [19:0] outvec;

   assign outvec = {sum, cout, ovf, zero, neg};

   cla_addsub_pipe #(.WIDTH(16), .LANE_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a), .b_i(b), .op_i(op), .cin_i(cin),
`ifdef CLA_ADDSUB_SAT_EN
      .sat_i(sat),
`endif
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .sum_o(sum), .cout_o(cout), .ovf_o(ovf), .zero_o(zero), .neg_o(neg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic, signed range check for overflow
   function automatic logic [19:0] model(input logic [1:0] o, input logic [15:0] x,
                                         input logic [15:0] y, input logic c, input logic s);
      logic [15:0] beff, r;
      logic [16:0] full;
      logic        ci, ov;
      int          st;
      beff = o[0] ? ~y : y;
      ci   = (o == 2'b00) ? 1'b0 : (o == 2'b01) ? 1'b1 : c;
      full = {1'b0, x} + {1'b0, beff} + {16'b0, ci};
      st   = int'($signed(x)) + int'($signed(beff)) + int'(ci);
      ov   = (st > 32767) || (st < -32768);
      r    = full[15:0];
`ifdef CLA_ADDSUB_SAT_EN
      if (s && ov) r = (st > 0) ? 16'h7FFF : 16'h8000;
`else
      if (s && 1'b0) r = 16'h0;
`endif
      return {r, full[16], ov, r == 16'h0, r[15]};
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (out_valid) begin
            if (prev_stall) chk("hold_during_stall", {12'b0, outvec}, {12'b0, prev_out});
            if (out_ready) begin
               if (q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
               else begin
                  chk("scoreboard_result", {12'b0, outvec}, {12'b0, q.pop_front()});
                  deliv_cyc.push_back(cyc);
               end
            end
         end
         if (in_valid && in_ready) q.push_back(model(op, a, b, cin, sat));
         prev_stall = out_valid && !out_ready;
         prev_out   = outvec;
      end
   end

   function automatic logic [15:0] rand_word();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic rand_inputs();
      a = rand_word(); b = rand_word(); op = 2'($urandom); cin = 1'($urandom);
`ifdef CLA_ADDSUB_SAT_EN
      sat = 1'($urandom);
`endif
   endtask

   task automatic send(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic c, input logic s);
      int n;
      op = o; a = x; b = y; cin = c; sat = s; in_valid = 1'b1;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (n == 100) chk("send_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0; out_ready = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(posedge clk); #2;
         if (q.size() == 0) break;
      end
      chk("drain_empty", q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic directed(input string nm, input logic [1:0] o, input logic [15:0] x,
                           input logic [15:0] y, input logic c, input logic s,
                           input logic [19:0] exp);
      drain();
      send(o, x, y, c, s);
      @(posedge clk); #1;
      chk({nm, "_not_yet_valid"}, {31'b0, out_valid}, 0);
      @(posedge clk); #1;
      chk({nm, "_valid_at_latency"}, {31'b0, out_valid}, 1);
      chk({nm, "_outputs"}, {12'b0, outvec}, {12'b0, exp});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Model pinned against hand-computed values
      chk("model_add_carry", {12'b0, model(2'b00, 16'h00FF, 16'h0001, 0, 0)}, {12'b0, 16'h0100, 4'b0000});
      chk("model_sub_ovf",   {12'b0, model(2'b01, 16'h8000, 16'h0001, 0, 0)}, {12'b0, 16'h7FFF, 4'b1100});
      chk("model_adc_wrap",  {12'b0, model(2'b10, 16'hFFFF, 16'h0000, 1, 0)}, {12'b0, 16'h0000, 4'b1010});
      chk("model_sbc_eq",    {12'b0, model(2'b11, 16'h0005, 16'h0005, 1, 0)}, {12'b0, 16'h0000, 4'b1010});

      #1;
      chk("reset_out_valid", {31'b0, out_valid}, 0);
      chk("reset_outputs", {12'b0, outvec}, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("in_ready_after_reset", {31'b0, in_ready}, 1);

      directed("add_cross_lane", 2'b00, 16'h00FF, 16'h0001, 0, 0, {16'h0100, 4'b0000});
      directed("sub_overflow",   2'b01, 16'h8000, 16'h0001, 0, 0, {16'h7FFF, 4'b1100});
`ifdef CLA_ADDSUB_SAT_EN
      directed("sub_saturate",   2'b01, 16'h8000, 16'h0001, 0, 1, {16'h8000, 4'b1101});
`endif
      directed("adc_wrap",       2'b10, 16'hFFFF, 16'h0000, 1, 0, {16'h0000, 4'b1010});
      directed("sbc_equal",      2'b11, 16'h0005, 16'h0005, 1, 0, {16'h0000, 4'b1010});

      // Ten back-to-back beats must emerge on consecutive cycles
      drain();
      deliv_cyc.delete();
      for (int i = 0; i < 10; i++) begin
         rand_inputs();
         send(op, a, b, cin, sat);
      end
      drain();
      chk("b2b_count", deliv_cyc.size(), 10);
      for (int i = 1; i < deliv_cyc.size(); i++)
         chk("b2b_consecutive", deliv_cyc[i] - deliv_cyc[i-1], 1);

      // Three-cycle output stall with input continuously offered
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         rand_inputs();
         in_valid  = 1'b1;
         out_ready = !(i >= 3 && i < 6);
         if (i >= 3 && i < 6) begin
            @(negedge clk);
            chk("stall_in_ready_low", {31'b0, in_ready}, 0);
            chk("stall_out_valid_high", {31'b0, out_valid}, 1);
         end
      end
      drain();

      // Reset with beats in flight
      send(2'b00, 16'h1234, 16'h1111, 0, 0);
      send(2'b00, 16'h0001, 16'h0002, 0, 0);
      send(2'b00, 16'h0003, 16'h0004, 0, 0);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_outputs", {12'b0, outvec}, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      chk("rst_no_ghost", {31'b0, out_valid}, 0);
      @(posedge clk); #1;
      directed("post_rst_add", 2'b00, 16'h0001, 16'h0001, 0, 0, {16'h0002, 4'b0000});

      // Randomized traffic with random back-pressure and bubbles
      deliv_cyc.delete();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         rand_inputs();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      drain();
      chk("random_traffic_flowed", {31'b0, deliv_cyc.size() > 1000}, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cla_addsub_pipe.md
CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width; SHALL be a multiple of LANE_W, at least LANE_W.
REQ-002 SHALL have parameter LANE_W, default 8: carry-lookahead lane width; one lane resolves per pipeline stage.
REQ-003 SHALL derive NL = WIDTH/LANE_W, the stage count and latency.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand beat offered.
REQ-007 in_ready  out  1  block accepts a beat this cycle.
REQ-008 a  in  WIDTH  operand A.
REQ-009 b  in  WIDTH  operand B.
REQ-010 op  in  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
REQ-011 cin  in  1  carry-in, used by ADC/SBC only.
REQ-012 out_valid  out  1  result beat present.
REQ-013 out_ready  in  1  consumer takes result.
REQ-014 sum  out  WIDTH  result.
REQ-015 cout  out  1  carry out of MSB (for SUB: 1 = no borrow).
REQ-016 ovf  out  1  signed overflow.
REQ-017 zero  out  1  sum == 0.
REQ-018 neg  out  1  sum[WIDTH-1].

Function
REQ-019 Effective B SHALL be b for ADD/ADC and ~b for SUB/SBC; effective carry-in SHALL be 0 (ADD), 1 (SUB), cin (ADC, SBC).
REQ-020 Within a lane: P = A^B, G = A&B, carry-lookahead per bit, sum = P^C; lane carry-out passes registered to the next stage.
REQ-021 Stage k SHALL compute lane k (LSB lane = stage 0); unprocessed upper operand bits and completed lower sum bits SHALL travel skewed in stage registers.
REQ-022 Each stage SHALL hold a valid bit; transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-023 Pipeline SHALL advance as one (global stall): adv = !out_valid | out_ready; in_ready = adv.
REQ-024 Latency SHALL be exactly NL cycles from accepting edge to out_valid with no stall; throughput one beat/cycle.
REQ-025 While out_valid & !out_ready, sum, cout, ovf, zero, neg and all stage contents SHALL hold unchanged.
REQ-026 Accept and deliver in the same cycle SHALL both occur with no bubble.
REQ-027 ovf SHALL equal (A_msb == Beff_msb) & (sum_msb != A_msb); flags SHALL be registered with sum.
REQ-028 Bubbles (in_valid low) SHALL propagate as invalid stages; out_valid never asserts for a bubble.
REQ-029 Beat order SHALL be preserved; no beat dropped or duplicated.

Reset
REQ-030 rst high SHALL asynchronously clear all stage valids, out_valid, sum, cout, ovf, neg to 0 and zero to 0.
REQ-031 Beats in flight when rst asserts SHALL be discarded; in_ready SHALL be 1 from the first edge after rst deasserts.

Configuration
REQ-032 Macro CLA_ADDSUB_SAT_EN defined: input port sat (1 bit, sampled with operands) SHALL exist; when sat=1 and ovf=1, sum SHALL clamp to signed max (0111..1) if A_msb=0, signed min (1000..0) if A_msb=1; ovf still reports 1; zero/neg SHALL reflect the clamped sum.
REQ-033 Macro undefined: sat port absent; sum always wraps modulo 2^WIDTH.

Verification (WIDTH=16, LANE_W=8, NL=2)
REQ-034 ADD a=0x00FF, b=0x0001 -> 2 cycles later sum=0x0100, cout=0, ovf=0, zero=0 (cross-lane carry).
REQ-035 SUB a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1, neg=0; with CLA_ADDSUB_SAT_EN and sat=1 -> sum=0x8000, ovf=1, neg=1.
REQ-036 ADC a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, zero=1; SBC a=5, b=5, cin=1 -> sum=0, zero=1, cout=1.
REQ-037 10 back-to-back beats with out_ready=1 -> 10 results on consecutive cycles in order; then out_ready=0 for 3 cycles -> output held stable, in_ready=0, no loss.
REQ-038 rst pulsed with 2 beats in flight -> out_valid=0, all outputs 0 immediately; next accepted beat ADD 1+1 -> sum=0x0002 after 2 cycles.
